// File: rtl/seq_pkg.sv
// Shared definitions for the seq_* family of bit-serial datapaths.
package seq_pkg;

    // Default operand width shared by the seq_comp and seq_sipo blocks.
    localparam int SEQ_N = 32;

    // Framing FSM states; the encoding is fixed so that the values match
    // the existing seq_comp-family datapaths.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_bit_counter.sv
// Received-bit counter with synchronous clear, count enable and terminal flag.
module seq_bit_counter #(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Count register: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // High while the next enabled bit is the Nth one, so the count reaches N
    // on the same edge that samples that bit.
    always_comb begin
        tc = (count == LAST);
    end

endmodule

// File: rtl/seq_sipo_rx.sv
// Bit-serial receiver: assembles an N-bit word LSB first and presents it in
// parallel, framed by a start/done/ack handshake.
module seq_sipo_rx
    import seq_pkg::*;
#(
    parameter int N  = SEQ_N,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          serial_in,
    input  logic          bit_valid,
    input  logic          ack,
    output logic [N-1:0]  parallel_out,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [CW-1:0] bit_count
);

    seq_state_t   state;
    seq_state_t   next_state;
    logic [N-1:0] sr;
    logic [N-1:0] sr_shifted;
    logic         accept_start;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;

    seq_bit_counter #(
        .N  (N),
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bit_count),
        .tc    (cnt_tc)
    );

    // Next-state and control decode; start in SHIFT restarts and drops the
    // bit presented in that same cycle.
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        sr_shifted   = {serial_in, sr[N-1:1]};
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state   = ST_SHIFT;
                    accept_start = 1'b1;
                    cnt_clr      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    accept_start = 1'b1;
                    cnt_clr      = 1'b1;
                end else if (bit_valid) begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ack) begin
                    cnt_clr = 1'b1;
                    if (start) begin
                        next_state   = ST_SHIFT;
                        accept_start = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            sr           <= '0;
            parallel_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == ST_SHIFT);
            done  <= (next_state == ST_DONE);

            if (accept_start) begin
                sr <= '0;
            end else if (cnt_en) begin
                sr <= sr_shifted;
            end

            if (cnt_en && cnt_tc) begin
                parallel_out <= sr_shifted;
            end

            // Set on a bit arriving while the word is unclaimed; an accepted
            // start in the same cycle clears it instead.
            if (accept_start) begin
                overrun <= 1'b0;
            end else if (state == ST_DONE && bit_valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
